mult_rr_scheduler: RTL and testbench
====================================

# mult_rr_scheduler

Round-robin scheduler that shares one `mydesign_comb` 3-bit signed multiplier LUT among `N_REQ` requesters. Each requester has its own valid/ready operand port. A two-stage stall-able pipeline (operand register, then result register) drives a single tagged response port. An optional per-requester accumulator turns the shared multiplier into a time-multiplexed MAC.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters, 2..8.
- `N_IN`, 3: operand width; passed to the multiplier instance.
- `N_OUT`, 6: product width; passed to the multiplier instance.
- `ACC_W`, 10: response/accumulator width, ≥ `N_OUT`.
- `ID_W` (localparam): `$clog2(N_REQ)`.

Ports:
- `clk_i  in  1`: single clock, rising edge.
- `rst_i  in  1`: asynchronous, active-high reset.
- `req_valid_i  in  N_REQ`: operand valid, one bit per requester.
- `req_ready_o  out  N_REQ`: operand accepted (one-hot or zero).
- `req_a_i  in  N_REQ*N_IN`: operand A; requester i occupies slice [i*N_IN +: N_IN], two's complement.
- `req_b_i  in  N_REQ*N_IN`: operand B, same packing as `req_a_i`.
- `req_last_i  in  N_REQ`: closes an accumulation; used only with `MULT_SCHED_ACC_EN`.
- `rsp_valid_o  out  1`: response valid.
- `rsp_ready_i  in  1`: response consumer ready.
- `rsp_id_o  out  ID_W`: index of the requester the response belongs to.
- `rsp_data_o  out  ACC_W`: signed result.
- `busy_o  out  1`: high when any pipeline stage holds an entry.

## Operation
- **Handshake.** A transfer on requester i occurs when `req_valid_i[i] & req_ready_o[i]`. Requesters hold valid and operands stable until accepted. `req_ready_o` may depend on `req_valid_i`.
- **Arbitration.** The round-robin pointer `ptr` resets to 0. The winner is the first valid requester at or after `ptr`, searching upward with wrap. After a grant to requester i, `ptr` becomes (i+1) mod N_REQ. `ptr` is unchanged in cycles with no grant.
- **S1 (operand register).** S1 captures a, b, id and last from the winner. S1 accepts when it is empty or S1 is advancing. Only the winner's `req_ready_o` bit is raised, and only when S1 accepts.
- **Multiply.** The S1 operands feed one `mydesign_comb` instance combinationally. The product is two's complement, range −12..16, and is sign-extended to `ACC_W`.
- **S2 (response register).** S2 loads when `!rsp_valid_o | rsp_ready_i`. `rsp_*` hold steady while `rsp_valid_o & !rsp_ready_i`.
- **Stall.** A full S2 under backpressure blocks S1, which deasserts all `req_ready_o` bits. No entry is dropped or reordered.
- **Reset mid-operation.** Reset discards S1/S2 contents and clears `ptr`. With the macro defined, it also clears all accumulators.
- **Reset values.** `req_ready_o`=0, `rsp_valid_o`=0, `rsp_id_o`=0, `rsp_data_o`=0, `busy_o`=0.

## Timing
- **Latency.** A request accepted at edge k produces `rsp_valid_o`=1 after edge k+1. The product reaches the response register one cycle after the operand capture.
- **Throughput.** One request per cycle across all requesters when `rsp_ready_i` stays high.
- **Combinational paths.**
  - `rsp_ready_i` → `req_ready_o` (stall propagation).
  - `req_valid_i` → `req_ready_o`.
  - There is no combinational path from `req_a_i`/`req_b_i` to any output.
- **Simultaneous events.** S2 draining and refilling in the same cycle is a full-rate transfer with no bubble.

## Configuration
- **`MULT_SCHED_ACC_EN` defined:**
  - There are `N_REQ` accumulators `acc[i]` of width `ACC_W`, all reset to 0.
  - When an S1 entry from requester i advances, compute `sum = acc[i] + sext(prod)`, wrapping mod 2^ACC_W.
  - If `last`=0: `acc[i] <= sum` and no response is produced. S1 still advances without needing S2 space.
  - If `last`=1: S2 receives `sum` and `acc[i] <= 0`.
  - A non-last entry never stalls on backpressure.
- **Undefined:**
  - No accumulators exist.
  - `req_last_i` is ignored.
  - Every request yields one response with `rsp_data_o = sext(prod)`.

## Test plan
- **Single product.** Reset, then requester 0 sends a=3, b=3 with `rsp_ready_i`=1. Required: `rsp_valid_o` is high in the second cycle after acceptance, `rsp_data_o`=9, `rsp_id_o`=0.
- **Extremes.** With no accumulator (`MULT_SCHED_ACC_EN` undefined), sign extension is checked on two cases:
  - a=−4, b=−4 → `rsp_data_o`=16 (0x010).
  - a=−4, b=3 → `rsp_data_o`=−12 (0x3F4).
- **Fairness.** All 4 requesters hold valid continuously for 8 grants. Required: grant order 0,1,2,3,0,1,2,3 and responses back-to-back with no bubbles.
- **Backpressure.** Hold `rsp_ready_i`=0 for 5 cycles with 3 requests pending. Required:
  - The first response holds stable.
  - After S1 fills, all `req_ready_o`=0.
  - After release, responses appear in grant order with no loss.
- **Accumulate (`MULT_SCHED_ACC_EN`).** Requester 2 sends (2,3,last=0), (−1,3,last=0), (3,3,last=1). Required: exactly one response, `rsp_data_o`=12, `rsp_id_o`=2, `acc[2]`=0 afterwards.
- **Reset mid-operation.** Assert `rst_i` with S1 and S2 full (and a partial accumulation in ACC builds). Required:
  - All outputs return to their reset values immediately.
  - The first grant after reset goes to requester 0.
  - With `MULT_SCHED_ACC_EN`, the next accumulation starts from 0.

Source files
------------

// File: rtl/mult_rr_scheduler.sv
// Round-robin scheduler sharing one 3-bit signed multiplier across N_REQ requesters; 2-stage stall-able pipeline.
// Optional per-requester accumulate (MAC) mode is enabled by defining MULT_SCHED_ACC_EN.

module mydesign_comb #(
  parameter int N_IN  = 3,
  parameter int N_OUT = 6
) (
  input  logic [N_IN-1:0]  a_i,
  input  logic [N_IN-1:0]  b_i,
  output logic [N_OUT-1:0] p_o
);
  logic signed [N_OUT-1:0] a_ext;
  logic signed [N_OUT-1:0] b_ext;

  assign a_ext = {{(N_OUT-N_IN){a_i[N_IN-1]}}, a_i};
  assign b_ext = {{(N_OUT-N_IN){b_i[N_IN-1]}}, b_i};
  assign p_o   = a_ext * b_ext;
endmodule

module mult_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int N_IN  = 3,
  parameter int N_OUT = 6,
  parameter int ACC_W = 10,
  localparam int ID_W = $clog2(N_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*N_IN-1:0]  req_a_i,
  input  logic [N_REQ*N_IN-1:0]  req_b_i,
  input  logic [N_REQ-1:0]       req_last_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [ACC_W-1:0]       rsp_data_o,
  output logic                   busy_o
);
  logic [ID_W-1:0]  ptr;
  logic             s1_vld;
  logic [N_IN-1:0]  s1_a;
  logic [N_IN-1:0]  s1_b;
  logic [ID_W-1:0]  s1_id;
  logic             s1_last;
  logic             s2_load;
  logic             s1_adv;
  logic             s1_accept;
  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic [ID_W-1:0]  cand;
  logic             grant;
  logic [N_OUT-1:0] prod;
  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] s2_din;
  logic             s2_new;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = ID_W'((int'(ptr) + k) % N_REQ);
      if (!win_found && req_valid_i[cand]) begin
        win_found = 1'b1;
        win_id    = cand;
      end
    end
  end

  mydesign_comb #(.N_IN(N_IN), .N_OUT(N_OUT)) u_mult (
    .a_i (s1_a),
    .b_i (s1_b),
    .p_o (prod)
  );

  assign prod_ext = ACC_W'($signed(prod));
  assign s2_load  = !rsp_valid_o || rsp_ready_i;

`ifdef MULT_SCHED_ACC_EN
  logic [ACC_W-1:0] acc [N_REQ];
  logic [ACC_W-1:0] acc_sum;

  assign acc_sum = acc[s1_id] + prod_ext;
  // Non-last entries only update the accumulator, so they never wait on S2.
  assign s1_adv  = s1_vld && (!s1_last || s2_load);
  assign s2_new  = s1_vld && s1_last;
  assign s2_din  = acc_sum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_REQ; i++) acc[i] <= '0;
    end else if (s1_adv) begin
      acc[s1_id] <= s1_last ? '0 : acc_sum;
    end
  end
`else
  logic unused_last;

  assign unused_last = ^req_last_i ^ s1_last;
  assign s1_adv      = s1_vld && s2_load;
  assign s2_new      = s1_vld;
  assign s2_din      = prod_ext;
`endif

  assign s1_accept   = !s1_vld || s1_adv;
  assign grant       = win_found && s1_accept && !rst_i;
  assign req_ready_o = grant ? (N_REQ'(1) << win_id) : '0;
  assign busy_o      = s1_vld || rsp_valid_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ptr     <= '0;
      s1_vld  <= 1'b0;
      s1_a    <= '0;
      s1_b    <= '0;
      s1_id   <= '0;
      s1_last <= 1'b0;
    end else begin
      if (s1_accept) begin
        s1_vld <= grant;
      end
      if (grant) begin
        s1_a    <= req_a_i[win_id*N_IN +: N_IN];
        s1_b    <= req_b_i[win_id*N_IN +: N_IN];
        s1_id   <= win_id;
        s1_last <= req_last_i[win_id];
        ptr     <= (win_id == ID_W'(N_REQ-1)) ? '0 : win_id + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rsp_valid_o <= 1'b0;
      rsp_id_o    <= '0;
      rsp_data_o  <= '0;
    end else if (s2_load) begin
      rsp_valid_o <= s2_new;
      if (s2_new) begin
        rsp_id_o   <= s1_id;
        rsp_data_o <= s2_din;
      end
    end
  end
endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed bench for mult_rr_scheduler: inputs driven on the falling edge, outputs sampled 1ns later.
module tb_mult_rr_scheduler;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  req_valid_i;
  logic [3:0]  req_ready_o;
  logic [11:0] req_a_i;
  logic [11:0] req_b_i;
  logic [3:0]  req_last_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [1:0]  rsp_id_o;
  logic [9:0]  rsp_data_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  mult_rr_scheduler dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_last_i  (req_last_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_id_o    (rsp_id_o),
    .rsp_data_o  (rsp_data_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input int a, input int b, input logic last);
    req_valid_i[i]        = v;
    req_a_i[i*3 +: 3]     = 3'(a);
    req_b_i[i*3 +: 3]     = 3'(b);
    req_last_i[i]         = last;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // One isolated request with the consumer always ready; response two samples later.
  task automatic single(input int id, input int a, input int b, input logic [9:0] exp, input string tag);
    @(negedge clk_i);
    set_req(id, 1'b1, a, b, 1'b1);
    #1 check({tag, "_rdy"}, 32'(req_ready_o), 32'(4'b1 << id));
    @(negedge clk_i);
    req_valid_i[id] = 1'b0;
    #1 check({tag, "_lat"}, 32'(rsp_valid_o), 0);
    @(negedge clk_i);
    #1;
    check({tag, "_vld"}, 32'(rsp_valid_o), 1);
    check({tag, "_dat"}, 32'(rsp_data_o), 32'(exp));
    check({tag, "_id"},  32'(rsp_id_o), 32'(id));
  endtask

  initial begin
    logic [9:0] fexp [4];
    fexp[0] = 10'h001; fexp[1] = 10'h002; fexp[2] = 10'h003; fexp[3] = 10'h3FE;
    rst_i = 1'b1;
    req_valid_i = '0; req_a_i = '0; req_b_i = '0; req_last_i = '1;
    rsp_ready_i = 1'b1;
    #12;
    check("rst_ready", 32'(req_ready_o), 0);
    check("rst_rvld",  32'(rsp_valid_o), 0);
    check("rst_id",    32'(rsp_id_o), 0);
    check("rst_data",  32'(rsp_data_o), 0);
    check("rst_busy",  32'(busy_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;

    single(0, 3, 3, 10'h009, "prod9");
    single(1, -4, -4, 10'h010, "max16");
    single(1, -4, 3, 10'h3F4, "min12");

    // Fairness: all four hold valid, expect 0,1,2,3,0,1,2,3 with no bubbles.
    do_reset();
    @(negedge clk_i);
    set_req(0, 1'b1, 1, 1, 1'b1);
    set_req(1, 1'b1, 2, 1, 1'b1);
    set_req(2, 1'b1, 3, 1, 1'b1);
    set_req(3, 1'b1, -1, 2, 1'b1);
    for (int g = 0; g < 8; g++) begin
      if (g > 0) @(negedge clk_i);
      #1 check("fair_grant", 32'(req_ready_o), 32'(4'b1 << (g % 4)));
      if (g >= 2) begin
        check("fair_vld", 32'(rsp_valid_o), 1);
        check("fair_id",  32'(rsp_id_o), 32'((g - 2) % 4));
        check("fair_dat", 32'(rsp_data_o), 32'(fexp[(g - 2) % 4]));
      end
    end
    @(negedge clk_i);
    req_valid_i = '0;
    #1 check("fair_tail_id2", 32'(rsp_id_o), 2);
    @(negedge clk_i);
    #1 check("fair_tail_id3", 32'(rsp_id_o), 3);
    check("fair_tail_dat3", 32'(rsp_data_o), 32'(10'h3FE));
    @(negedge clk_i);
    #1 check("fair_drain", 32'(rsp_valid_o), 0);

    // Backpressure: three requests, consumer stalls for cycles 0..5.
    do_reset();
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    set_req(0, 1'b1, 1, 1, 1'b1);
    set_req(1, 1'b1, 1, 2, 1'b1);
    set_req(2, 1'b1, 1, 3, 1'b1);
    #1 check("bp_rdy0", 32'(req_ready_o), 32'(4'b0001));
    @(negedge clk_i);
    req_valid_i[0] = 1'b0;
    #1 check("bp_rdy1", 32'(req_ready_o), 32'(4'b0010));
    @(negedge clk_i);
    req_valid_i[1] = 1'b0;
    for (int c = 2; c <= 5; c++) begin
      if (c > 2) @(negedge clk_i);
      #1;
      check("bp_stall_rdy", 32'(req_ready_o), 0);
      check("bp_hold_vld",  32'(rsp_valid_o), 1);
      check("bp_hold_id",   32'(rsp_id_o), 0);
      check("bp_hold_dat",  32'(rsp_data_o), 1);
    end
    @(negedge clk_i);
    rsp_ready_i = 1'b1;
    #1 check("bp_release_rdy", 32'(req_ready_o), 32'(4'b0100));
    @(negedge clk_i);
    req_valid_i[2] = 1'b0;
    #1 check("bp_r1_id", 32'(rsp_id_o), 1);
    check("bp_r1_dat", 32'(rsp_data_o), 2);
    @(negedge clk_i);
    #1 check("bp_r2_id", 32'(rsp_id_o), 2);
    check("bp_r2_dat", 32'(rsp_data_o), 3);
    @(negedge clk_i);
    #1 check("bp_empty_vld", 32'(rsp_valid_o), 0);
    check("bp_empty_busy", 32'(busy_o), 0);

`ifdef MULT_SCHED_ACC_EN
    do_reset();
    @(negedge clk_i);
    set_req(2, 1'b1, 2, 3, 1'b0);
    #1 check("acc_rdy0", 32'(req_ready_o), 32'(4'b0100));
    @(negedge clk_i);
    set_req(2, 1'b1, -1, 3, 1'b0);
    #1 check("acc_rdy1", 32'(req_ready_o), 32'(4'b0100));
    check("acc_novld1", 32'(rsp_valid_o), 0);
    @(negedge clk_i);
    set_req(2, 1'b1, 3, 3, 1'b1);
    #1 check("acc_novld2", 32'(rsp_valid_o), 0);
    @(negedge clk_i);
    req_valid_i[2] = 1'b0;
    #1 check("acc_novld3", 32'(rsp_valid_o), 0);
    @(negedge clk_i);
    #1 check("acc_vld", 32'(rsp_valid_o), 1);
    check("acc_dat", 32'(rsp_data_o), 12);
    check("acc_id",  32'(rsp_id_o), 2);
    check("acc_clr", 32'(dut.acc[2]), 0);
    @(negedge clk_i);
    #1 check("acc_once", 32'(rsp_valid_o), 0);
    // Leave a partial sum on requester 2 so the reset below must clear it.
    @(negedge clk_i);
    set_req(2, 1'b1, 1, 1, 1'b0);
    @(negedge clk_i);
    req_valid_i[2] = 1'b0;
    @(negedge clk_i);
    #1 check("acc_partial", 32'(dut.acc[2]), 1);
`endif

    // Reset mid-operation with S1 and S2 both holding entries.
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    set_req(0, 1'b1, 1, 1, 1'b1);
    set_req(1, 1'b1, 1, 1, 1'b1);
    set_req(2, 1'b1, 1, 1, 1'b1);
    set_req(3, 1'b1, 1, 1, 1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    #1 check("mid_full_busy", 32'(busy_o), 1);
    check("mid_full_vld", 32'(rsp_valid_o), 1);
    rst_i = 1'b1;
    #1;
    check("mid_rst_rdy",  32'(req_ready_o), 0);
    check("mid_rst_vld",  32'(rsp_valid_o), 0);
    check("mid_rst_id",   32'(rsp_id_o), 0);
    check("mid_rst_dat",  32'(rsp_data_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    rsp_ready_i = 1'b1;
    req_valid_i = '0;
`ifdef MULT_SCHED_ACC_EN
    set_req(2, 1'b1, 2, 2, 1'b1);
`else
    set_req(0, 1'b1, 2, 2, 1'b1);
    set_req(2, 1'b1, 2, 2, 1'b1);
`endif
    req_valid_i[3] = 1'b1;
#1 check("post_rst_grant", 32'(req_ready_o), 32'(`ifdef MULT_SCHED_ACC_EN 4'b0100 `else 4'b0001 `endif));
    @(negedge clk_i);
    req_valid_i = '0;
    @(negedge clk_i);
    #1 check("post_rst_dat", 32'(rsp_data_o), 4);
`ifndef MULT_SCHED_ACC_EN
    check("post_rst_id", 32'(rsp_id_o), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout got %0d expected %0d", 0, 1);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
